// File: rtl/sirv_debug_entry_ctrl.sv
// rtl/sirv_debug_entry_ctrl.sv - debug-mode entry/exit sequencer between commit and dcsr/dpc.
// Single-step support (step_armed, cause 4) is built only when SIRV_DBG_STEP_EN is defined.
module sirv_debug_entry_ctrl #(
   parameter int                 PC_SIZE = 32,
   parameter logic [PC_SIZE-1:0] DBG_VEC = PC_SIZE'(32'h800)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               dbg_irq,
   input  logic               dbg_halt_r,
   input  logic               dbg_step_r,
   input  logic               dbg_ebreakm_r,
   input  logic [PC_SIZE-1:0] dpc_r,
   input  logic               cmt_valid,
   input  logic [PC_SIZE-1:0] cmt_pc,
   input  logic [PC_SIZE-1:0] cmt_npc,
   input  logic               cmt_ebreak,
   input  logic               cmt_dret,
   output logic               dbg_irq_r,
   output logic [PC_SIZE-1:0] cmt_dpc,
   output logic               cmt_dpc_ena,
   output logic [2:0]         cmt_dcause,
   output logic               cmt_dcause_ena,
   output logic               dbg_flush,
   output logic [PC_SIZE-1:0] dbg_flush_pc,
   output logic               dbg_active
);

`ifdef SIRV_DBG_STEP_EN
   localparam logic STEP_EN = 1'b1;
`else
   localparam logic STEP_EN = 1'b0;
`endif

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_ENTER = 2'd1;
   localparam logic [1:0] ST_DEBUG = 2'd2;
   localparam logic [1:0] ST_EXIT  = 2'd3;

   localparam logic [2:0] CAUSE_NONE    = 3'd0;
   localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
   localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
   localparam logic [2:0] CAUSE_STEP    = 3'd4;
   localparam logic [2:0] CAUSE_HALT    = 3'd5;

   logic [1:0]         state_q, state_d;
   logic               irq_q;
   logic               step_armed_q, step_armed_d;
   logic [PC_SIZE-1:0] dpc_q, dpc_d;
   logic [2:0]         cause_q, cause_d;
   logic               step_hit;

   assign step_hit = step_armed_q & STEP_EN;

   always_comb begin
      state_d      = state_q;
      step_armed_d = step_armed_q;
      dpc_d        = dpc_q;
      cause_d      = cause_q;
      case (state_q)
         ST_RUN: begin
            if (cmt_valid) begin
               if (cmt_ebreak && dbg_ebreakm_r) begin
                  cause_d = CAUSE_EBREAK;
                  dpc_d   = cmt_pc;
                  state_d = ST_ENTER;
               end else if (irq_q) begin
                  cause_d = CAUSE_HALTREQ;
                  dpc_d   = cmt_npc;
                  state_d = ST_ENTER;
               end else if (dbg_halt_r) begin
                  cause_d = CAUSE_HALT;
                  dpc_d   = cmt_npc;
                  state_d = ST_ENTER;
               end else if (step_hit) begin
                  cause_d = CAUSE_STEP;
                  dpc_d   = cmt_npc;
                  state_d = ST_ENTER;
               end
            end
         end
         ST_ENTER: begin
            step_armed_d = 1'b0;
            state_d      = ST_DEBUG;
         end
         ST_DEBUG: begin
            // Clearing the held cause here makes the EXIT strobe carry 0 (leave debug mode).
            if (cmt_valid && cmt_dret) begin
               cause_d = CAUSE_NONE;
               state_d = ST_EXIT;
            end
         end
         default: begin
            step_armed_d = dbg_step_r & STEP_EN;
            state_d      = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         irq_q        <= 1'b0;
         step_armed_q <= 1'b0;
         dpc_q        <= '0;
         cause_q      <= CAUSE_NONE;
      end else begin
         state_q      <= state_d;
         irq_q        <= dbg_irq;
         step_armed_q <= step_armed_d;
         dpc_q        <= dpc_d;
         cause_q      <= cause_d;
      end
   end

   always_comb begin
      cmt_dpc_ena    = 1'b0;
      cmt_dcause_ena = 1'b0;
      dbg_flush      = 1'b0;
      dbg_flush_pc   = '0;
      case (state_q)
         ST_ENTER: begin
            cmt_dpc_ena    = 1'b1;
            cmt_dcause_ena = 1'b1;
            dbg_flush      = 1'b1;
            dbg_flush_pc   = DBG_VEC;
         end
         ST_DEBUG: begin
            // EBREAK inside debug mode just restarts the debug ROM, no dpc/cause update.
            if (cmt_valid && cmt_ebreak) begin
               dbg_flush    = 1'b1;
               dbg_flush_pc = DBG_VEC;
            end
         end
         ST_EXIT: begin
            cmt_dcause_ena = 1'b1;
            dbg_flush      = 1'b1;
            dbg_flush_pc   = dpc_r;
         end
         default: ;
      endcase
   end

   assign dbg_irq_r  = irq_q;
   assign cmt_dpc    = dpc_q;
   assign cmt_dcause = cause_q;
   assign dbg_active = (state_q == ST_ENTER) || (state_q == ST_DEBUG);

endmodule

// File: tb/tb_sirv_debug_entry_ctrl.sv
// tb/tb_sirv_debug_entry_ctrl.sv - bench for sirv_debug_entry_ctrl: vector table, corner sequences, random vs model.
// Follows SIRV_DBG_STEP_EN the same way as the design.
module tb_sirv_debug_entry_ctrl;

`ifdef SIRV_DBG_STEP_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        dbg_irq, dbg_halt_r, dbg_step_r, dbg_ebreakm_r;
   logic [31:0] dpc_r, cmt_pc, cmt_npc;
   logic        cmt_valid, cmt_ebreak, cmt_dret;
   logic        dbg_irq_r, cmt_dpc_ena, cmt_dcause_ena, dbg_flush, dbg_active;
   logic [31:0] cmt_dpc, dbg_flush_pc;
   logic [2:0]  cmt_dcause;

   sirv_debug_entry_ctrl #(.PC_SIZE(32), .DBG_VEC(32'h800)) dut (
      .clk(clk), .rst_n(rst_n), .dbg_irq(dbg_irq), .dbg_halt_r(dbg_halt_r),
      .dbg_step_r(dbg_step_r), .dbg_ebreakm_r(dbg_ebreakm_r), .dpc_r(dpc_r),
      .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_npc(cmt_npc),
      .cmt_ebreak(cmt_ebreak), .cmt_dret(cmt_dret), .dbg_irq_r(dbg_irq_r),
      .cmt_dpc(cmt_dpc), .cmt_dpc_ena(cmt_dpc_ena), .cmt_dcause(cmt_dcause),
      .cmt_dcause_ena(cmt_dcause_ena), .dbg_flush(dbg_flush),
      .dbg_flush_pc(dbg_flush_pc), .dbg_active(dbg_active)
   );

   typedef struct packed {
      logic        irq, halt, step, ebm;
      logic [31:0] dpcr;
      logic        valid;
      logic [31:0] pc, npc;
      logic        eb, dr;
   } inp_t;

   typedef struct {
      inp_t        i;
      logic [71:0] e;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: debug-mode flag, the one-cycle strobe scheduled by the last event, held dpc/cause.
   bit          m_in_dbg;
   int          m_sched;     // 0 nothing, 1 entry strobes, 2 exit strobes
   bit          m_step;
   logic [31:0] m_dpc;
   logic [2:0]  m_cause;
   bit          m_irq_r;

   function automatic vec_t mk(input logic irq, halt, step, ebm, input logic [31:0] dpcr,
                               input logic valid, input logic [31:0] pc, npc, input logic eb, dr,
                               input logic e_irq, input logic [31:0] e_dpc, input logic e_den,
                               input logic [2:0] e_c, input logic e_cen, e_fl,
                               input logic [31:0] e_fpc, input logic e_act);
      vec_t r;
      r.i = {irq, halt, step, ebm, dpcr, valid, pc, npc, eb, dr};
      r.e = {e_irq, e_dpc, e_den, e_c, e_cen, e_fl, e_fpc, e_act};
      return r;
   endfunction

   function automatic logic [71:0] outv();
      return {dbg_irq_r, cmt_dpc, cmt_dpc_ena, cmt_dcause, cmt_dcause_ena, dbg_flush, dbg_flush_pc, dbg_active};
   endfunction

   function automatic logic [71:0] model_out();
      logic        dbg_eb;
      logic [31:0] fpc;
      dbg_eb = m_in_dbg && (m_sched == 0) && cmt_valid && cmt_ebreak;
      fpc = (m_sched == 1 || dbg_eb) ? 32'h800 : (m_sched == 2) ? dpc_r : 32'h0;
      return {m_irq_r, m_dpc, (m_sched == 1), m_cause, (m_sched != 0), ((m_sched != 0) || dbg_eb), fpc, m_in_dbg};
   endfunction

   task automatic model_reset();
      m_in_dbg = 0; m_sched = 0; m_step = 0; m_dpc = '0; m_cause = '0; m_irq_r = 0;
   endtask

   task automatic model_advance();
      int         nxt;
      logic [2:0] c;
      nxt = 0;
      c = 3'd0;
      if (m_sched == 1) m_step = 0;
      else if (m_sched == 2) m_step = STEP_EN && dbg_step_r;
      else if (!m_in_dbg && cmt_valid) begin
         if (cmt_ebreak && dbg_ebreakm_r) c = 3'd1;
         else if (m_irq_r) c = 3'd3;
         else if (dbg_halt_r) c = 3'd5;
         else if (m_step) c = 3'd4;
         if (c != 3'd0) begin
            m_cause = c;
            m_dpc = (c == 3'd1) ? cmt_pc : cmt_npc;
            m_in_dbg = 1;
            nxt = 1;
         end
      end else if (m_in_dbg && cmt_valid && cmt_dret) begin
         m_in_dbg = 0;
         m_cause = 3'd0;
         nxt = 2;
      end
      m_sched = nxt;
      m_irq_r = dbg_irq;
   endtask

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (irq_r|dpc|dpc_en|cause|cause_en|flush|flush_pc|active) t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic apply(input inp_t v);
      dbg_irq = v.irq; dbg_halt_r = v.halt; dbg_step_r = v.step; dbg_ebreakm_r = v.ebm;
      dpc_r = v.dpcr; cmt_valid = v.valid; cmt_pc = v.pc; cmt_npc = v.npc;
      cmt_ebreak = v.eb; cmt_dret = v.dr;
   endtask

   task automatic cyc(input inp_t v, input logic rst);
      @(posedge clk);
      #1;
      rst_n = rst;
      apply(v);
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("model", outv(), model_out());
      if (rst_n) model_advance();
   endtask

   vec_t tbl[22];
   inp_t v, idle;
   bit   irq_s;
   logic [71:0] e_step;

   initial begin
      idle = '0;
      apply(idle);
      model_reset();
      //                 irq hlt stp ebm dpc_r       v  pc          npc         eb dr | irq_r dpc   den c cen fl fpc        act
      tbl[0]  = mk(0,0,0,1, 32'h0,   0, 32'h0,   32'h0,   0,0, 0, 32'h0,   0,3'd0,0,0, 32'h0,   0);
      tbl[1]  = mk(0,0,0,1, 32'h0,   1, 32'h100, 32'h104, 1,0, 0, 32'h0,   0,3'd0,0,0, 32'h0,   0);
      tbl[2]  = mk(0,0,0,1, 32'h0,   0, 32'h0,   32'h0,   0,0, 0, 32'h100, 1,3'd1,1,1, 32'h800, 1);
      tbl[3]  = mk(0,0,0,1, 32'h0,   1, 32'h800, 32'h804, 1,0, 0, 32'h100, 0,3'd1,0,1, 32'h800, 1);
      tbl[4]  = mk(0,0,0,1, 32'h300, 1, 32'h804, 32'h808, 0,1, 0, 32'h100, 0,3'd1,0,0, 32'h0,   1);
      tbl[5]  = mk(0,0,0,1, 32'h300, 0, 32'h0,   32'h0,   0,0, 0, 32'h100, 0,3'd0,1,1, 32'h300, 0);
      tbl[6]  = mk(1,0,0,1, 32'h300, 0, 32'h0,   32'h0,   0,0, 0, 32'h100, 0,3'd0,0,0, 32'h0,   0);
      tbl[7]  = mk(1,0,0,1, 32'h300, 1, 32'h200, 32'h204, 0,0, 1, 32'h100, 0,3'd0,0,0, 32'h0,   0);
      tbl[8]  = mk(1,0,0,1, 32'h300, 0, 32'h0,   32'h0,   0,0, 1, 32'h204, 1,3'd3,1,1, 32'h800, 1);
      tbl[9]  = mk(0,0,0,1, 32'h300, 1, 32'h800, 32'h804, 0,0, 1, 32'h204, 0,3'd3,0,0, 32'h0,   1);
      tbl[10] = mk(1,0,0,1, 32'h204, 1, 32'h804, 32'h808, 0,1, 0, 32'h204, 0,3'd3,0,0, 32'h0,   1);
      tbl[11] = mk(1,0,0,1, 32'h204, 0, 32'h0,   32'h0,   0,0, 1, 32'h204, 0,3'd0,1,1, 32'h204, 0);
      tbl[12] = mk(1,0,0,1, 32'h204, 1, 32'h500, 32'h504, 1,0, 1, 32'h204, 0,3'd0,0,0, 32'h0,   0);
      tbl[13] = mk(1,0,0,1, 32'h204, 0, 32'h0,   32'h0,   0,0, 1, 32'h500, 1,3'd1,1,1, 32'h800, 1);
      tbl[14] = mk(1,0,0,1, 32'h504, 1, 32'h800, 32'h804, 0,1, 1, 32'h500, 0,3'd1,0,0, 32'h0,   1);
      tbl[15] = mk(1,0,0,1, 32'h504, 0, 32'h0,   32'h0,   0,0, 1, 32'h500, 0,3'd0,1,1, 32'h504, 0);
      tbl[16] = mk(1,0,0,1, 32'h504, 1, 32'h504, 32'h508, 0,0, 1, 32'h500, 0,3'd0,0,0, 32'h0,   0);
      tbl[17] = mk(0,0,0,1, 32'h504, 0, 32'h0,   32'h0,   0,0, 1, 32'h508, 1,3'd3,1,1, 32'h800, 1);
      tbl[18] = mk(0,0,0,1, 32'h508, 1, 32'h800, 32'h804, 0,1, 0, 32'h508, 0,3'd3,0,0, 32'h0,   1);
      tbl[19] = mk(0,0,0,1, 32'h508, 0, 32'h0,   32'h0,   0,0, 0, 32'h508, 0,3'd0,1,1, 32'h508, 0);
      tbl[20] = mk(0,0,0,0, 32'h508, 1, 32'h508, 32'h50c, 1,0, 0, 32'h508, 0,3'd0,0,0, 32'h0,   0);
      tbl[21] = mk(0,0,0,0, 32'h508, 0, 32'h0,   32'h0,   0,0, 0, 32'h508, 0,3'd0,0,0, 32'h0,   0);

      cyc(idle, 1'b0);
      cyc(idle, 1'b0);
      chk("reset_state", outv(), 72'd0);

      for (int k = 0; k < 22; k++) begin
         cyc(tbl[k].i, 1'b1);
         chk($sformatf("vec%0d", k), outv(), tbl[k].e);
      end

      // Single step: enter via dcsr.halt, resume with step set, one commit in RUN.
      cyc(idle, 1'b0);
      v = idle; v.halt = 1; v.valid = 1; v.pc = 32'h10; v.npc = 32'h14;
      cyc(v, 1'b1);
      cyc(idle, 1'b1);
      chk("halt_entry", {cmt_dcause, cmt_dpc, cmt_dcause_ena}, {3'd5, 32'h14, 1'b1});
      v = idle; v.dpcr = 32'h400; v.step = 1; v.valid = 1; v.dr = 1;
      cyc(v, 1'b1);
      v = idle; v.dpcr = 32'h400; v.step = 1;
      cyc(v, 1'b1);
      chk("step_exit_flush", {dbg_flush, dbg_flush_pc, cmt_dcause_ena, cmt_dcause}, {1'b1, 32'h400, 1'b1, 3'd0});
      cyc(idle, 1'b1);
      chk("step_idle_no_entry", {dbg_active, cmt_dcause_ena}, 2'b00);
      v = idle; v.valid = 1; v.pc = 32'h400; v.npc = 32'h404;
      cyc(v, 1'b1);
      cyc(idle, 1'b1);
      e_step = STEP_EN ? {1'b1, 3'd4, 32'h404, 1'b1} : {1'b0, 3'd0, 32'h14, 1'b0};
      chk("step_commit", {cmt_dcause_ena, cmt_dcause, cmt_dpc, dbg_active}, e_step);

      // Reset asserted during ENTER.
      cyc(idle, 1'b0);
      v = idle; v.ebm = 1; v.valid = 1; v.eb = 1; v.pc = 32'h100; v.npc = 32'h104;
      cyc(v, 1'b1);
      cyc(idle, 1'b0);
      chk("rst_in_enter", outv(), 72'd0);
      cyc(idle, 1'b0);
      cyc(idle, 1'b1);
      chk("rst_release_run", outv(), 72'd0);
      cyc(idle, 1'b1);
      chk("rst_no_late_entry", outv(), 72'd0);

      irq_s = 0;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 11) == 0) irq_s = ~irq_s;
         v.irq   = irq_s;
         v.halt  = ($urandom_range(0, 19) == 0);
         v.step  = $urandom_range(0, 1);
         v.ebm   = $urandom_range(0, 1);
         v.dpcr  = $urandom & 32'h0000_fffc;
         v.valid = $urandom_range(0, 1);
         v.pc    = $urandom & 32'h0000_fffc;
         v.npc   = v.pc + 32'd4;
         case ($urandom_range(0, 6))
            0: begin v.eb = 1; v.dr = 0; end
            1: begin v.eb = 0; v.dr = 1; end
            default: begin v.eb = 0; v.dr = 0; end
         endcase
         cyc(v, ($urandom_range(0, 399) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
